// File: rtl/decode_dga_pfifo_ctl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_dga_pkg
// Shared types and constants for the DECODE panel FIFO controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
package decode_dga_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_CMD  = 2'd1,
    W_STS  = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_PULSE = 2'd1,
    R_WAIT  = 2'd2
  } rd_state_e;

  // Upper nibble written with a status insert; bit 7 marks status entries.
  localparam logic [3:0] STS_TAG = 4'b1000;

  localparam int PFIFO_DEPTH = 13;

endpackage
`default_nettype wire

// File: rtl/decode_dga_pfifo_ctl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_dga_pfifo_ctl_if
// Command/status/read handshake and FIFO-side signals of the panel FIFO
// controller. master = IDB/POW/panel side, slave = controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface decode_dga_pfifo_ctl_if;
  logic       LDPANCN;
  logic [7:0] IDBI_7_0;
  logic       STSRQN;
  logic [3:0] STS_3_0;
  logic       STSACK;
  logic       RMMN;
  logic       CLRFLGN;
  logic       FWE;
  logic [7:0] FDI_7_0;
  logic       FRE;
  logic [4:0] CNT_4_0;
  logic       EMPN;
  logic       FULN;
  logic       OVFN;

  modport master (
    output LDPANCN, IDBI_7_0, STSRQN, STS_3_0, RMMN, CLRFLGN,
    input  STSACK, FWE, FDI_7_0, FRE, CNT_4_0, EMPN, FULN, OVFN
  );

  modport slave (
    input  LDPANCN, IDBI_7_0, STSRQN, STS_3_0, RMMN, CLRFLGN,
    output STSACK, FWE, FDI_7_0, FRE, CNT_4_0, EMPN, FULN, OVFN
  );
endinterface
`default_nettype wire

// File: rtl/decode_dga_fall_det.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_dga_fall_det
// Optional two-flop synchronizer followed by a registered falling-edge
// detector. fall_o is high in the cycle the (synchronized) level is 0 while
// the previously sampled level was 1. Flops reset to 1 (idle-high strobes).
// Revision: 1.0
// ---------------------------------------------------------------------------
module decode_dga_fall_det #(
  parameter bit SYNC_EN = 1'b0
) (
  input  logic CLK,
  input  logic CLEAR,
  input  logic sig_i,
  output logic lvl_o,
  output logic fall_o
);

  logic sig_cur;
  logic prev_q;

  generate
    if (SYNC_EN) begin : g_sync
      logic s1_q;
      logic s2_q;
      // Two-flop synchronizer for a strobe from an unrelated clock domain.
      always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
          s1_q <= 1'b1;
          s2_q <= 1'b1;
        end else begin
          s1_q <= sig_i;
          s2_q <= s1_q;
        end
      end
      assign sig_cur = s2_q;
    end else begin : g_nosync
      assign sig_cur = sig_i;
    end
  endgenerate

  // Remember the last sampled level for edge detection.
  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) prev_q <= 1'b1;
    else        prev_q <= sig_cur;
  end

  assign lvl_o  = sig_cur;
  assign fall_o = prev_q & ~sig_cur;

endmodule
`default_nettype wire

// File: rtl/decode_dga_pfifo_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_dga_pfifo_ctl
// Panel FIFO controller: arbitrates command loads against status inserts,
// sequences reads, and owns occupancy count and EMPN/FULN/OVFN flags.
// Build option: PFIFO_RMM_SYNC_EN - synchronize RMMN (two flops) before edge
// detection, adding two cycles of read latency.
// Revision: 1.0
// ---------------------------------------------------------------------------
module decode_dga_pfifo_ctl
  import decode_dga_pkg::*;
#(
  parameter int DEPTH = PFIFO_DEPTH
) (
  input  logic                    CLK,
  input  logic                    CLEAR,
  decode_dga_pfifo_ctl_if.slave   bus
);

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

`ifdef PFIFO_RMM_SYNC_EN
  localparam bit RMM_SYNC = 1'b1;
`else
  localparam bit RMM_SYNC = 1'b0;
`endif

  wr_state_e  wr_q;
  rd_state_e  rd_q;
  logic       fwe_q;
  logic       fre_q;
  logic       stsack_q;
  logic [7:0] fdi_q;
  logic       ovfn_q;
  logic       arm_q;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;

  logic       cmd_fall;
  logic       cmd_lvl_unused;
  logic       rmm_fall;
  logic       rmm_lvl;
  logic       wr_full;

  decode_dga_fall_det #(.SYNC_EN(1'b0)) u_cmd_det (
    .CLK    (CLK),
    .CLEAR  (CLEAR),
    .sig_i  (bus.LDPANCN),
    .lvl_o  (cmd_lvl_unused),
    .fall_o (cmd_fall)
  );

  decode_dga_fall_det #(.SYNC_EN(RMM_SYNC)) u_rmm_det (
    .CLK    (CLK),
    .CLEAR  (CLEAR),
    .sig_i  (bus.RMMN),
    .lvl_o  (rmm_lvl),
    .fall_o (rmm_fall)
  );

  // A write issued last cycle is not yet in cnt_q; count it so back-to-back
  // writes can never push the occupancy past DEPTH. Reads are ignored here.
  assign wr_full = ((cnt_q + 5'(fwe_q)) >= DEPTH_C);

  // Write FSM: command falls always win, status inserts only from idle.
  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      wr_q     <= W_IDLE;
      fwe_q    <= 1'b0;
      stsack_q <= 1'b0;
      fdi_q    <= 8'h00;
      ovfn_q   <= 1'b1;
      arm_q    <= 1'b1;
    end else begin
      fwe_q    <= 1'b0;
      stsack_q <= 1'b0;
      if (!bus.CLRFLGN) ovfn_q <= 1'b1;
      if (bus.STSRQN)   arm_q  <= 1'b1;
      if (cmd_fall) begin
        wr_q <= W_CMD;
        if (wr_full) begin
          ovfn_q <= 1'b0;
        end else begin
          fwe_q <= 1'b1;
          fdi_q <= bus.IDBI_7_0;
        end
      end else if (wr_q == W_IDLE && !bus.STSRQN && arm_q && !wr_full) begin
        wr_q     <= W_STS;
        fwe_q    <= 1'b1;
        stsack_q <= 1'b1;
        fdi_q    <= {STS_TAG, bus.STS_3_0};
        arm_q    <= 1'b0;
      end else begin
        wr_q <= W_IDLE;
      end
    end
  end

  // Read FSM: one FRE per RMMN low period; empty reads are silently ignored.
  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      rd_q  <= R_IDLE;
      fre_q <= 1'b0;
    end else begin
      fre_q <= 1'b0;
      case (rd_q)
        R_IDLE: begin
          if (rmm_fall && cnt_q != 5'd0) begin
            rd_q  <= R_PULSE;
            fre_q <= 1'b1;
          end
        end
        R_PULSE: rd_q <= R_WAIT;
        R_WAIT:  if (rmm_lvl) rd_q <= R_IDLE;
        default: rd_q <= R_IDLE;
      endcase
    end
  end

  // Occupancy follows the issued pulses; simultaneous write and read cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (fwe_q && !fre_q)      cnt_d = cnt_q + 5'd1;
    else if (fre_q && !fwe_q) cnt_d = cnt_q - 5'd1;
  end

  // Occupancy register.
  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) cnt_q <= 5'd0;
    else        cnt_q <= cnt_d;
  end

  assign bus.FWE     = fwe_q;
  assign bus.FDI_7_0 = fdi_q;
  assign bus.FRE     = fre_q;
  assign bus.STSACK  = stsack_q;
  assign bus.CNT_4_0 = cnt_q;
  assign bus.EMPN    = (cnt_q != 5'd0);
  assign bus.FULN    = (cnt_q != DEPTH_C);
  assign bus.OVFN    = ovfn_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_dga_pfifo_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decode_dga_pfifo_ctl
// Directed bench for the panel FIFO controller with a write-data scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_decode_dga_pfifo_ctl;

  logic CLK;
  logic CLEAR;
  int   checks;
  int   fails;
  int   fre_count;
  int   sts_count;
  logic [7:0] exp_q[$];

  decode_dga_pfifo_ctl_if bus_if();

  decode_dga_pfifo_ctl #(.DEPTH(13)) dut (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .bus   (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every FWE must match the oldest expected write.
  always @(negedge CLK) begin
    if (CLEAR === 1'b1) begin
      if (bus_if.FWE === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL fwe_unexpected observed=FWE expected=no_write fdi=%0h", bus_if.FDI_7_0);
        end
        if (exp_q.size() != 0) chk("sb_fdi", bus_if.FDI_7_0, exp_q.pop_front());
      end
      if (bus_if.FRE === 1'b1)    fre_count++;
      if (bus_if.STSACK === 1'b1) sts_count++;
    end
  end

  task automatic cmd_load(input logic [7:0] d, input bit accept);
    bus_if.IDBI_7_0 = d;
    bus_if.LDPANCN  = 1'b0;
    if (accept) exp_q.push_back(d);
    tick();
    bus_if.LDPANCN = 1'b1;
    tick();
  endtask

  task automatic rd_strobe();
    bus_if.RMMN = 1'b0;
    tick();
    bus_if.RMMN = 1'b1;
    tick();
    tick();
  endtask

  int  snap;
  bit  seen;

  initial begin
    checks = 0; fails = 0; fre_count = 0; sts_count = 0;
    CLEAR = 1'b0;
    bus_if.LDPANCN = 1'b1; bus_if.IDBI_7_0 = 8'h00; bus_if.STSRQN = 1'b1;
    bus_if.STS_3_0 = 4'h0; bus_if.RMMN = 1'b1; bus_if.CLRFLGN = 1'b1;
    tick(); tick();
    chk("rst_fwe",    8'(bus_if.FWE),     8'h0);
    chk("rst_fre",    8'(bus_if.FRE),     8'h0);
    chk("rst_fdi",    bus_if.FDI_7_0,     8'h00);
    chk("rst_stsack", 8'(bus_if.STSACK),  8'h0);
    chk("rst_cnt",    8'(bus_if.CNT_4_0), 8'd0);
    chk("rst_empn",   8'(bus_if.EMPN),    8'h0);
    chk("rst_fuln",   8'(bus_if.FULN),    8'h1);
    chk("rst_ovfn",   8'(bus_if.OVFN),    8'h1);
    CLEAR = 1'b1;
    tick();

    // First command: FWE one cycle after the fall with the sampled data.
    bus_if.IDBI_7_0 = 8'h5A; bus_if.LDPANCN = 1'b0; exp_q.push_back(8'h5A);
    tick();
    chk("cmd_fwe", 8'(bus_if.FWE), 8'h1);
    chk("cmd_fdi", bus_if.FDI_7_0, 8'h5A);
    bus_if.LDPANCN = 1'b1;
    tick();
    chk("cmd_cnt",  8'(bus_if.CNT_4_0), 8'd1);
    chk("cmd_empn", 8'(bus_if.EMPN),    8'h1);

    // Fill to 13, then an overflowing 14th load.
    for (int i = 1; i < 13; i++) cmd_load(8'(8'h10 + i), 1'b1);
    chk("full_cnt",  8'(bus_if.CNT_4_0), 8'd13);
    chk("full_fuln", 8'(bus_if.FULN),    8'h0);
    bus_if.IDBI_7_0 = 8'hEE; bus_if.LDPANCN = 1'b0;
    tick();
    chk("ovf_fwe",  8'(bus_if.FWE),  8'h0);
    chk("ovf_ovfn", 8'(bus_if.OVFN), 8'h0);
    bus_if.LDPANCN = 1'b1;
    tick();
    chk("ovf_cnt", 8'(bus_if.CNT_4_0), 8'd13);
    bus_if.CLRFLGN = 1'b0;
    tick();
    bus_if.CLRFLGN = 1'b1;
    chk("clr_ovfn", 8'(bus_if.OVFN), 8'h1);

    // Status waits while full; a read frees a slot and the insert follows.
    bus_if.STS_3_0 = 4'h3; bus_if.STSRQN = 1'b0;
    tick(); tick(); tick();
    chk("sts_wait_ack", 8'(sts_count), 8'd0);
    exp_q.push_back(8'h83);
    bus_if.RMMN = 1'b0;
    tick();
    chk("rd_fre", 8'(bus_if.FRE), 8'h1);
    bus_if.RMMN = 1'b1;
    tick();
    chk("rd_cnt", 8'(bus_if.CNT_4_0), 8'd12);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (bus_if.STSACK === 1'b1) seen = 1'b1;
    end
    chk("sts_after_rd", 8'(seen), 8'h1);
    bus_if.STSRQN = 1'b1;
    tick();
    chk("sts_cnt", 8'(bus_if.CNT_4_0), 8'd13);

    // Drain completely, then an ignored read at empty.
    snap = fre_count;
    for (int i = 0; i < 13; i++) rd_strobe();
    chk("drain_fre",  8'(fre_count - snap), 8'd13);
    chk("drain_cnt",  8'(bus_if.CNT_4_0),   8'd0);
    chk("drain_empn", 8'(bus_if.EMPN),      8'h0);
    snap = fre_count;
    rd_strobe();
    chk("empty_fre", 8'(fre_count - snap), 8'd0);
    chk("empty_cnt", 8'(bus_if.CNT_4_0),   8'd0);

    // Command and status requested together: command first, then 0x86 once.
    snap = sts_count;
    bus_if.STS_3_0 = 4'h6; bus_if.STSRQN = 1'b0;
    bus_if.IDBI_7_0 = 8'h21; bus_if.LDPANCN = 1'b0;
    exp_q.push_back(8'h21); exp_q.push_back(8'h86);
    tick();
    chk("arb_cmd_fdi", bus_if.FDI_7_0,    8'h21);
    chk("arb_cmd_ack", 8'(bus_if.STSACK), 8'h0);
    bus_if.LDPANCN = 1'b1;
    tick(); tick();
    chk("arb_sts_fwe", 8'(bus_if.FWE),    8'h1);
    chk("arb_sts_fdi", bus_if.FDI_7_0,    8'h86);
    chk("arb_sts_ack", 8'(bus_if.STSACK), 8'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("arb_one_ack", 8'(sts_count - snap), 8'd1);
    chk("arb_cnt",     8'(bus_if.CNT_4_0),   8'd2);
    bus_if.STSRQN = 1'b1;
    tick();

    // RMMN held low for 5 cycles gives exactly one read.
    cmd_load(8'h33, 1'b1);
    chk("hold_pre_cnt", 8'(bus_if.CNT_4_0), 8'd3);
    snap = fre_count;
    bus_if.RMMN = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus_if.RMMN = 1'b1;
    tick(); tick();
    chk("hold_fre", 8'(fre_count - snap), 8'd1);
    chk("hold_cnt", 8'(bus_if.CNT_4_0),   8'd2);

    // Reset during a status insert drops the pulses immediately.
    bus_if.STS_3_0 = 4'h9; bus_if.STSRQN = 1'b0;
    tick();
    chk("mid_ack_pre", 8'(bus_if.STSACK), 8'h1);
    CLEAR = 1'b0;
    #1;
    chk("mid_fwe",    8'(bus_if.FWE),     8'h0);
    chk("mid_stsack", 8'(bus_if.STSACK),  8'h0);
    chk("mid_cnt",    8'(bus_if.CNT_4_0), 8'd0);
    chk("mid_empn",   8'(bus_if.EMPN),    8'h0);
    chk("mid_fuln",   8'(bus_if.FULN),    8'h1);
    chk("mid_ovfn",   8'(bus_if.OVFN),    8'h1);
    bus_if.STSRQN = 1'b1;
    tick();
    CLEAR = 1'b1;
    tick(); tick();
    chk("sb_empty", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
